icache_linefill_responder: RTL and testbench
============================================

// Module: icache_linefill_responder
// PURPOSE
//  Downstream-side responder for icache line-fill traffic. Accepts icache txreq (addr, txnid, MSHR entry id)
//  into an in-order request FIFO and fetches each line from a backing memory read port.
//  Returns the line on the rxdat channel tagged with txnid + entry id. Sits between icache_top and L2/memory model.
// PARAMETERS
//  ADDR_WIDTH      32   request address width
//  TXNID_WIDTH     5    transaction id width (= ICACHE_REQ_TXNID_WIDTH)
//  ENTRY_ID_WIDTH  3    MSHR entry id width (= MSHR_ENTRY_INDEX_WIDTH)
//  LINE_WIDTH      256  line data width (bits); LINE_OFS = log2(LINE_WIDTH/8)
//  OPCODE_WIDTH    4    txrsp opcode width (= ICACHE_REQ_OPCODE_WIDTH)
//  FIFO_DEPTH      4    request FIFO entries, power of 2, >=2
// PORTS
//  clk                 in   1               clock
//  rst_n               in   1               async active-low reset
//  txreq_vld           in   1               icache line-fill request valid
//  txreq_rdy           out  1               request accepted (FIFO not full)
//  txreq_addr          in   ADDR_WIDTH      request address
//  txreq_txnid         in   TXNID_WIDTH     request txnid
//  txreq_entry_id      in   ENTRY_ID_WIDTH  requesting MSHR entry
//  mem_rd_vld          out  1               memory read request
//  mem_rd_rdy          in   1               memory accepts read
//  mem_rd_addr         out  ADDR_WIDTH      line-aligned read address
//  mem_rsp_vld         in   1               memory read data valid (always accepted in WAIT)
//  mem_rsp_data        in   LINE_WIDTH      memory line data
//  rxdat_vld           out  1               line data to icache valid
//  rxdat_rdy           in   1               icache accepts data
//  rxdat_data          out  LINE_WIDTH      line data
//  rxdat_txnid         out  TXNID_WIDTH     echoed txnid
//  rxdat_entry_id      out  ENTRY_ID_WIDTH  echoed MSHR entry id
//  txrsp_vld           out  1               completion response valid
//  txrsp_rdy           in   1               icache accepts response
//  txrsp_opcode        out  OPCODE_WIDTH    response opcode
// BEHAVIOUR
//  - One clock clk; reset rst_n asynchronous, active-low. Reset: all vld outputs 0, data/id outputs 0, FIFO empty, FSM IDLE.
//  - Push on txreq_vld&&txreq_rdy; txreq_rdy = !full (not pop-aware: full FIFO refuses push even on same-cycle pop).
//  - FSM IDLE->MEM_RD when FIFO non-empty (head stays in FIFO until rxdat handshake).
//  - MEM_RD: mem_rd_vld=1, mem_rd_addr = head addr with low LINE_OFS bits zeroed; stable until mem_rd_rdy; then WAIT.
//  - WAIT: on mem_rsp_vld capture data into line register -> SEND. mem_rsp_vld outside WAIT ignored.
//  - SEND: rxdat_vld=1, payload registered, stable until rxdat_rdy; on handshake pop FIFO -> RSP (macro) or IDLE.
//  - Strictly in order, one memory read outstanding; min latency push->rxdat_vld = 3 cycles (push, MEM_RD, WAIT w/ same-cycle rsp).
//  - FIFO pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1; push and pop in same cycle keep count.
//  - Reset mid-transaction drops all queued/in-flight requests; late mem_rsp after reset is ignored (FSM in IDLE).
// CONFIGURATION
//  ICACHE_LINEFILL_RSP_EN defined: after rxdat handshake enter RSP; txrsp_vld=1, txrsp_opcode=RSP_OPCODE_LINEFILL_ACK
//   (4'h1) held until txrsp_rdy, then IDLE. Not defined: RSP state absent, txrsp_vld tied 0, txrsp_opcode tied 0.
// STRUCTURE
//  toy_pack: linefill_req_t {addr,txnid,entry_id}, downstream_rxdat_t reuse, RSP_OPCODE_LINEFILL_ACK, responder FSM enum.
//  Sub-module: icache_linefill_req_fifo (generic sync FIFO of linefill_req_t, full/empty/count).
// TESTING
//  1 Single req addr 0x0000_1234,txnid 3,entry 2 -> mem_rd_addr 0x0000_1220; rsp data D -> rxdat {D,3,2} once.
//  2 Push 5 back-to-back, mem_rd_rdy=0 -> txreq_rdy drops after 4th; 5th accepted after first pop; order preserved.
//  3 rxdat_rdy=0 for 10 cycles -> rxdat_vld and payload stable, no new mem_rd_vld, FIFO count unchanged.
//  4 Full FIFO, rxdat handshake and txreq_vld same cycle -> push refused that cycle, accepted next.
//  5 Assert rst_n=0 in WAIT, then mem_rsp_vld -> no rxdat_vld, FIFO empty, txreq_rdy=1.
//  6 With ICACHE_LINEFILL_RSP_EN, txrsp_rdy=0 3 cycles -> txrsp_vld held opcode 4'h1, next mem_rd only after ack.

Source files
------------

// File: rtl/icache_linefill_responder_pkg.sv
// rtl/icache_linefill_responder_pkg.sv - shared types and constants for the icache line-fill responder
//
// Purpose : widths, request/response structs, completion opcode, responder FSM
//           state type and a line-alignment helper shared by the responder,
//           its request FIFO and its bus interface.
// Ports   : none (package).
// Config  : ICACHE_LINEFILL_RSP_EN adds the RSP state to the FSM state type.
package icache_linefill_responder_pkg;

  localparam int ADDR_WIDTH     = 32;
  localparam int TXNID_WIDTH    = 5;
  localparam int ENTRY_ID_WIDTH = 3;
  localparam int LINE_WIDTH     = 256;
  localparam int OPCODE_WIDTH   = 4;
  localparam int LINE_OFS       = $clog2(LINE_WIDTH / 8);

  localparam logic [OPCODE_WIDTH-1:0] RSP_OPCODE_LINEFILL_ACK = 4'h1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]     addr;
    logic [TXNID_WIDTH-1:0]    txnid;
    logic [ENTRY_ID_WIDTH-1:0] entry_id;
  } linefill_req_t;

  typedef struct packed {
    logic [LINE_WIDTH-1:0]     data;
    logic [TXNID_WIDTH-1:0]    txnid;
    logic [ENTRY_ID_WIDTH-1:0] entry_id;
  } downstream_rxdat_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MEM_RD,
    ST_WAIT,
    ST_SEND
`ifdef ICACHE_LINEFILL_RSP_EN
    , ST_RSP
`endif
  } rsp_state_e;

  // Clear the byte-within-line offset so memory always sees a line address.
  function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] addr);
    line_align = {addr[ADDR_WIDTH-1:LINE_OFS], {LINE_OFS{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_linefill_responder_if.sv
// rtl/icache_linefill_responder_if.sv - handshake bundle between icache, responder and memory
//
// Purpose : groups the txreq, memory read, memory response, rxdat and txrsp
//           channels of the line-fill responder.
// Modports: slave  - responder view (accepts txreq, issues mem reads, returns rxdat/txrsp)
//           master - environment view (icache + memory model), directions mirrored
interface icache_linefill_responder_if;
  import icache_linefill_responder_pkg::*;

  logic                      txreq_vld;
  logic                      txreq_rdy;
  logic [ADDR_WIDTH-1:0]     txreq_addr;
  logic [TXNID_WIDTH-1:0]    txreq_txnid;
  logic [ENTRY_ID_WIDTH-1:0] txreq_entry_id;

  logic                      mem_rd_vld;
  logic                      mem_rd_rdy;
  logic [ADDR_WIDTH-1:0]     mem_rd_addr;
  logic                      mem_rsp_vld;
  logic [LINE_WIDTH-1:0]     mem_rsp_data;

  logic                      rxdat_vld;
  logic                      rxdat_rdy;
  logic [LINE_WIDTH-1:0]     rxdat_data;
  logic [TXNID_WIDTH-1:0]    rxdat_txnid;
  logic [ENTRY_ID_WIDTH-1:0] rxdat_entry_id;

  logic                      txrsp_vld;
  logic                      txrsp_rdy;
  logic [OPCODE_WIDTH-1:0]   txrsp_opcode;

  modport slave (
    input  txreq_vld, txreq_addr, txreq_txnid, txreq_entry_id,
    output txreq_rdy,
    output mem_rd_vld, mem_rd_addr,
    input  mem_rd_rdy,
    input  mem_rsp_vld, mem_rsp_data,
    output rxdat_vld, rxdat_data, rxdat_txnid, rxdat_entry_id,
    input  rxdat_rdy,
    output txrsp_vld, txrsp_opcode,
    input  txrsp_rdy
  );

  modport master (
    output txreq_vld, txreq_addr, txreq_txnid, txreq_entry_id,
    input  txreq_rdy,
    input  mem_rd_vld, mem_rd_addr,
    output mem_rd_rdy,
    output mem_rsp_vld, mem_rsp_data,
    input  rxdat_vld, rxdat_data, rxdat_txnid, rxdat_entry_id,
    output rxdat_rdy,
    input  txrsp_vld, txrsp_opcode,
    output txrsp_rdy
  );

endinterface

// File: rtl/icache_linefill_responder_req_fifo.sv
// rtl/icache_linefill_responder_req_fifo.sv - in-order request FIFO of line-fill requests
//
// Purpose : synchronous FIFO (module icache_linefill_req_fifo) holding
//           linefill_req_t entries; the head stays visible until popped.
// Ports   : clk, rst_n (async active-low)
//           push, push_data  - write side, ignored when full
//           pop              - read side, ignored when empty
//           head             - oldest entry
//           full, empty, count
module icache_linefill_req_fifo
  import icache_linefill_responder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  linefill_req_t           push_data,
  input  logic                    pop,
  output linefill_req_t           head,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  linefill_req_t    mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr] <= push_data;
    end
  end

  // Pointers are exactly log2(DEPTH) wide, so increment wraps modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/icache_linefill_responder.sv
// rtl/icache_linefill_responder.sv - downstream responder returning icache line fills from memory
//
// Purpose : queues icache line-fill requests in order, reads each line from
//           memory (one read outstanding) and returns it on rxdat tagged with
//           the request's txnid and MSHR entry id.
// Ports   : clk, rst_n (async active-low)
//           bus (icache_linefill_responder_if.slave):
//             txreq_*  - request in (addr, txnid, entry_id); rdy = FIFO not full
//             mem_rd_* - line-aligned memory read request
//             mem_rsp_* - memory line data, taken only while waiting for it
//             rxdat_*  - line data + echoed txnid/entry_id out
//             txrsp_*  - completion ack (only with ICACHE_LINEFILL_RSP_EN)
// Config  : ICACHE_LINEFILL_RSP_EN - after each rxdat handshake, send a
//           LINEFILL_ACK on txrsp before starting the next request.
module icache_linefill_responder
  import icache_linefill_responder_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  icache_linefill_responder_if.slave    bus
);

  rsp_state_e state;
  rsp_state_e state_nxt;

  linefill_req_t                 push_req;
  linefill_req_t                 head;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          push;
  logic                          pop;
  logic                          capture;

  logic [LINE_WIDTH-1:0]         line_q;
  logic [TXNID_WIDTH-1:0]        txnid_q;
  logic [ENTRY_ID_WIDTH-1:0]     entry_id_q;

  // Ready is not pop-aware: a full FIFO refuses even if a pop happens this cycle.
  assign bus.txreq_rdy     = !fifo_full;
  assign push              = bus.txreq_vld && !fifo_full;
  assign push_req.addr     = bus.txreq_addr;
  assign push_req.txnid    = bus.txreq_txnid;
  assign push_req.entry_id = bus.txreq_entry_id;

  icache_linefill_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_req),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The head entry is only popped after rxdat handshakes, so its txnid and
  // entry id are still available when the memory data arrives.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        // A same-cycle push already counts, giving the 3-cycle minimum latency.
        if (fifo_count != '0 || push) begin
          state_nxt = ST_MEM_RD;
        end
      end
      ST_MEM_RD: begin
        if (bus.mem_rd_rdy) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.mem_rsp_vld) begin
          capture   = 1'b1;
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bus.rxdat_rdy) begin
          pop = !fifo_empty;
`ifdef ICACHE_LINEFILL_RSP_EN
          state_nxt = ST_RSP;
`else
          state_nxt = ST_IDLE;
`endif
        end
      end
`ifdef ICACHE_LINEFILL_RSP_EN
      ST_RSP: begin
        if (bus.txrsp_rdy) begin
          state_nxt = ST_IDLE;
        end
      end
`endif
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q     <= '0;
      txnid_q    <= '0;
      entry_id_q <= '0;
    end else if (capture) begin
      line_q     <= bus.mem_rsp_data;
      txnid_q    <= head.txnid;
      entry_id_q <= head.entry_id;
    end
  end

  assign bus.mem_rd_vld     = (state == ST_MEM_RD);
  assign bus.mem_rd_addr    = (state == ST_MEM_RD) ? line_align(head.addr) : '0;

  assign bus.rxdat_vld      = (state == ST_SEND);
  assign bus.rxdat_data     = line_q;
  assign bus.rxdat_txnid    = txnid_q;
  assign bus.rxdat_entry_id = entry_id_q;

`ifdef ICACHE_LINEFILL_RSP_EN
  assign bus.txrsp_vld      = (state == ST_RSP);
  assign bus.txrsp_opcode   = (state == ST_RSP) ? RSP_OPCODE_LINEFILL_ACK : '0;
`else
  logic unused_txrsp_rdy;
  assign unused_txrsp_rdy   = bus.txrsp_rdy;
  assign bus.txrsp_vld      = 1'b0;
  assign bus.txrsp_opcode   = '0;
`endif

endmodule

// File: tb/tb_icache_linefill_responder.sv
// tb/tb_icache_linefill_responder.sv - randomized scoreboard bench for the icache line-fill responder
`timescale 1ns/1ps
module tb_icache_linefill_responder;

  localparam int DEPTH = 4;
`ifdef ICACHE_LINEFILL_RSP_EN
  localparam bit RSP_EN = 1'b1;
`else
  localparam bit RSP_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic [4:0]  txnid;
    logic [2:0]  entry;
  } req_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  icache_linefill_responder_if bus ();

  icache_linefill_responder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    total++;
    bad++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Reference model: memory content of a line is a fixed arithmetic function of its line address.
  function automatic logic [31:0] align32(input logic [31:0] a);
    return a - (a % 32);
  endfunction

  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i*32 +: 32] = ((a * 32'd2654435761) ^ (32'(i) * 32'h0101_0101)) + a;
    end
    return r;
  endfunction

  req_t        stim_q[$];
  req_t        rx_q[$];
  logic [31:0] rd_q[$];

  int gap_pct = 0;
  bit mem_hold = 0;
  int mem_dmin = 0;
  int mem_dmax = 3;
  bit rx_hold = 0;
  int rx_pct = 70;
  bit rsp_hold = 0;
  int rsp_pct = 70;

  task automatic enqueue(input logic [31:0] a, input logic [4:0] t, input logic [2:0] e);
    req_t r;
    r.addr = a;
    r.txnid = t;
    r.entry = e;
    stim_q.push_back(r);
  endtask

  // Request driver: expected results are queued the moment a request is accepted.
  bit   drv_busy = 0;
  req_t cur;
  int   accepted = 0;
  initial begin : driver
    bus.txreq_vld = 1'b0;
    bus.txreq_addr = '0;
    bus.txreq_txnid = '0;
    bus.txreq_entry_id = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!drv_busy && stim_q.size() > 0 && $urandom_range(99, 0) >= gap_pct) begin
        cur = stim_q.pop_front();
        drv_busy = 1;
      end
      bus.txreq_vld = drv_busy;
      bus.txreq_addr = drv_busy ? cur.addr : '0;
      bus.txreq_txnid = drv_busy ? cur.txnid : '0;
      bus.txreq_entry_id = drv_busy ? cur.entry : '0;
      @(negedge clk);
      if (drv_busy && rst_n && bus.txreq_rdy) begin
        rd_q.push_back(align32(cur.addr));
        rx_q.push_back(cur);
        accepted++;
        drv_busy = 0;
      end
    end
  end

  // Memory model: one response per accepted read after a random delay, plus
  // stray responses when no read is outstanding (must be ignored).
  bit          pend = 0;
  logic [31:0] pend_addr = '0;
  int          pend_wait = 0;
  initial begin : mem_model
    bus.mem_rd_rdy = 1'b0;
    bus.mem_rsp_vld = 1'b0;
    bus.mem_rsp_data = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_rsp_vld = 1'b0;
      if (pend) begin
        if (pend_wait == 0) begin
          bus.mem_rsp_vld = 1'b1;
          bus.mem_rsp_data = line_of(pend_addr);
          pend = 0;
        end else begin
          pend_wait--;
        end
      end else if ($urandom_range(7, 0) == 0) begin
        bus.mem_rsp_vld = 1'b1;
        bus.mem_rsp_data = {8{$urandom()}};
      end
      bus.mem_rd_rdy = !mem_hold && ($urandom_range(99, 0) < 60);
      @(negedge clk);
      if (rst_n && bus.mem_rd_vld && bus.mem_rd_rdy) begin
        pend = 1;
        pend_addr = bus.mem_rd_addr;
        pend_wait = $urandom_range(mem_dmax, mem_dmin);
      end
    end
  end

  initial begin : sink
    bus.rxdat_rdy = 1'b0;
    bus.txrsp_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.rxdat_rdy = !rx_hold && ($urandom_range(99, 0) < rx_pct);
      bus.txrsp_rdy = !rsp_hold && ($urandom_range(99, 0) < rsp_pct);
    end
  end

  // Monitor / scoreboard
  int          occ = 0;
  int          reads = 0;
  int          rx_done = 0;
  int          rsp_done = 0;
  logic [31:0] last_rd_addr = '0;
  bit          p_rd_stall = 0;
  bit          p_rx_stall = 0;
  bit          p_rsp_stall = 0;
  logic [31:0] p_rd_addr = '0;
  logic [255:0] p_rx_data = '0;
  logic [4:0]  p_rx_txnid = '0;
  logic [2:0]  p_rx_entry = '0;
  initial begin : monitor
    req_t        want;
    logic [31:0] drop;
    int          done_cnt;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        occ = 0; reads = 0; rx_done = 0; rsp_done = 0;
        rd_q.delete();
        rx_q.delete();
        p_rd_stall = 0; p_rx_stall = 0; p_rsp_stall = 0;
        continue;
      end
      check("txreq_rdy", bus.txreq_rdy, occ < DEPTH);

      if (p_rd_stall) begin
        check("mem_rd_vld_hold", bus.mem_rd_vld, 1'b1);
        check("mem_rd_addr_hold", bus.mem_rd_addr, p_rd_addr);
      end
      if (bus.mem_rd_vld) begin
        done_cnt = RSP_EN ? rsp_done : rx_done;
        check("one_outstanding", reads, done_cnt);
        if (rd_q.size() == 0) begin
          fail_now("mem_rd_unexpected", $sformatf("read of %0h with no request queued", bus.mem_rd_addr));
        end else begin
          check("mem_rd_addr", bus.mem_rd_addr, rd_q[0]);
        end
        if (bus.mem_rd_rdy) begin
          if (rd_q.size() > 0) drop = rd_q.pop_front();
          last_rd_addr = bus.mem_rd_addr;
          reads++;
        end
      end
      p_rd_stall = bus.mem_rd_vld && !bus.mem_rd_rdy;
      p_rd_addr = bus.mem_rd_addr;

      if (p_rx_stall) begin
        check("rxdat_vld_hold", bus.rxdat_vld, 1'b1);
        check("rxdat_data_hold", bus.rxdat_data, p_rx_data);
        check("rxdat_txnid_hold", bus.rxdat_txnid, p_rx_txnid);
        check("rxdat_entry_hold", bus.rxdat_entry_id, p_rx_entry);
      end
      if (bus.rxdat_vld && bus.rxdat_rdy) begin
        if (rx_q.size() == 0) begin
          fail_now("rxdat_unexpected", $sformatf("txnid %0h with nothing outstanding", bus.rxdat_txnid));
        end else begin
          want = rx_q.pop_front();
          check("rxdat_data", bus.rxdat_data, line_of(align32(want.addr)));
          check("rxdat_txnid", bus.rxdat_txnid, want.txnid);
          check("rxdat_entry_id", bus.rxdat_entry_id, want.entry);
        end
        rx_done++;
      end
      p_rx_stall = bus.rxdat_vld && !bus.rxdat_rdy;
      p_rx_data = bus.rxdat_data;
      p_rx_txnid = bus.rxdat_txnid;
      p_rx_entry = bus.rxdat_entry_id;

`ifdef ICACHE_LINEFILL_RSP_EN
      if (p_rsp_stall) check("txrsp_vld_hold", bus.txrsp_vld, 1'b1);
      if (bus.txrsp_vld) begin
        check("txrsp_opcode", bus.txrsp_opcode, 4'h1);
        check("txrsp_after_rxdat", rx_done - rsp_done, 1);
        if (bus.txrsp_rdy) rsp_done++;
      end
      p_rsp_stall = bus.txrsp_vld && !bus.txrsp_rdy;
`else
      check("txrsp_vld_tied", bus.txrsp_vld, 1'b0);
      check("txrsp_opcode_tied", bus.txrsp_opcode, 4'h0);
`endif

      if (bus.txreq_vld && bus.txreq_rdy) occ++;
      if (bus.rxdat_vld && bus.rxdat_rdy) occ--;
    end
  end

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((stim_q.size() != 0 || drv_busy || rx_q.size() != 0 ||
            (RSP_EN && rsp_done != rx_done)) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain_timeout"}, n >= budget, 1'b0);
  endtask

  initial begin : main
    int base;
    int n;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_txreq_rdy", bus.txreq_rdy, 1'b1);
    check("rst_mem_rd_vld", bus.mem_rd_vld, 1'b0);
    check("rst_mem_rd_addr", bus.mem_rd_addr, 32'h0);
    check("rst_rxdat_vld", bus.rxdat_vld, 1'b0);
    check("rst_rxdat_data", bus.rxdat_data, 256'h0);
    check("rst_rxdat_txnid", bus.rxdat_txnid, 5'h0);
    check("rst_rxdat_entry", bus.rxdat_entry_id, 3'h0);
    check("rst_txrsp_vld", bus.txrsp_vld, 1'b0);
    check("rst_txrsp_opcode", bus.txrsp_opcode, 4'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single request: line address 0x1220, echoed tags
    enqueue(32'h0000_1234, 5'd3, 3'd2);
    drain("t1", 200);
    check("t1_mem_rd_addr", last_rd_addr, 32'h0000_1220);
    check("t1_rx_count", rx_done, 1);

    // Five back-to-back with memory blocked: only four fit
    @(negedge clk);
    mem_hold = 1;
    base = accepted;
    for (int i = 0; i < 5; i++) enqueue($urandom(), 5'(10 + i), 3'(i));
    repeat (12) @(negedge clk);
    check("t2_accepted_blocked", accepted - base, 4);
    check("t2_txreq_rdy_low", bus.txreq_rdy, 1'b0);
    mem_hold = 0;
    drain("t2", 500);
    check("t2_accepted_total", accepted - base, 5);

    // rxdat stalled for 10 cycles
    @(negedge clk);
    rx_hold = 1;
    enqueue($urandom(), 5'd7, 3'd1);
    enqueue($urandom(), 5'd8, 3'd2);
    enqueue($urandom(), 5'd9, 3'd3);
    n = 0;
    while (!bus.rxdat_vld && n < 100) begin @(negedge clk); n++; end
    check("t3_wait_timeout", n >= 100, 1'b0);
    base = rx_done;
    repeat (10) @(negedge clk);
    check("t3_rxdat_vld_held", bus.rxdat_vld, 1'b1);
    check("t3_rxdat_txnid", bus.rxdat_txnid, 5'd7);
    check("t3_no_mem_rd", bus.mem_rd_vld, 1'b0);
    check("t3_no_pop", rx_done - base, 0);
    rx_hold = 0;
    drain("t3", 500);

    // Full FIFO: pop and pending push in the same cycle, push refused then taken
    @(negedge clk);
    rx_hold = 1;
    for (int i = 0; i < 6; i++) enqueue($urandom(), 5'(20 + i), 3'(i));
    repeat (30) @(negedge clk);
    check("t4_full_rdy", bus.txreq_rdy, 1'b0);
    check("t4_sending", bus.rxdat_vld, 1'b1);
    rx_hold = 0;
    rx_pct = 100;
    @(negedge clk);
    check("t4_pop_cycle_hs", bus.rxdat_vld && bus.rxdat_rdy, 1'b1);
    check("t4_pop_cycle_rdy", bus.txreq_rdy, 1'b0);
    check("t4_pop_cycle_vld", bus.txreq_vld, 1'b1);
    @(negedge clk);
    check("t4_next_cycle_rdy", bus.txreq_rdy, 1'b1);
    rx_pct = 70;
    drain("t4", 500);

    // Reset while waiting for memory; the late response must be ignored
    @(negedge clk);
    mem_dmin = 6;
    mem_dmax = 6;
    enqueue(32'h0000_8040, 5'd17, 3'd5);
    n = 0;
    while (!pend && n < 100) begin @(negedge clk); n++; end
    check("t5_wait_timeout", n >= 100, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("t5_rxdat_vld", bus.rxdat_vld, 1'b0);
    check("t5_txreq_rdy", bus.txreq_rdy, 1'b1);
    check("t5_mem_rd_vld", bus.mem_rd_vld, 1'b0);
    mem_dmin = 0;
    mem_dmax = 3;

`ifdef ICACHE_LINEFILL_RSP_EN
    // Completion ack held off for three cycles
    @(negedge clk);
    rsp_hold = 1;
    enqueue($urandom(), 5'd4, 3'd6);
    enqueue($urandom(), 5'd5, 3'd7);
    n = 0;
    while (!bus.txrsp_vld && n < 100) begin @(negedge clk); n++; end
    check("t6_wait_timeout", n >= 100, 1'b0);
    repeat (3) @(negedge clk);
    check("t6_txrsp_vld_held", bus.txrsp_vld, 1'b1);
    check("t6_txrsp_opcode", bus.txrsp_opcode, 4'h1);
    check("t6_no_mem_rd", bus.mem_rd_vld, 1'b0);
    rsp_hold = 0;
    drain("t6", 500);
`endif

    // Random traffic, moderate back-pressure
    @(negedge clk);
    gap_pct = 30;
    for (int i = 0; i < 150; i++) enqueue($urandom(), 5'($urandom_range(31, 0)), 3'($urandom_range(7, 0)));
    drain("rand1", 20000);

    // Random traffic, heavy back-pressure and slow memory
    @(negedge clk);
    gap_pct = 5;
    rx_pct = 20;
    rsp_pct = 30;
    mem_dmax = 6;
    for (int i = 0; i < 60; i++) enqueue($urandom(), 5'($urandom_range(31, 0)), 3'($urandom_range(7, 0)));
    drain("rand2", 20000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
